wshb_fb_slave: RTL and testbench

// Wishbone classic slave: word-addressed framebuffer memory that answers the
// VGA controller's 32-bit read stream and a pixel writer's byte-masked writes.

---
 rtl/wshb_fb_slave.sv | 151 +++++++++++++++
 tb/tb_wshb_fb_slave.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wshb_fb_slave.sv
// Wishbone classic framebuffer slave: word-addressed memory with byte-masked writes,
// programmable wait states and err termination for out-of-range accesses.
module wshb_fb_slave #(
    parameter int unsigned MEM_WORDS   = 384000,
    parameter int unsigned DEPTH_WIDTH = 19,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cyc,
    input  logic        stb,
    input  logic        we,
    input  logic [3:0]  sel,
    input  logic [31:0] adr,
    input  logic [31:0] dat_ms,
    output logic [31:0] dat_sm,
    output logic        ack,
    output logic        err
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] WAIT_LAST =
        CNT_W'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                   state, state_d;
    logic [CNT_W-1:0]         wait_cnt, wait_cnt_d;
    logic                     capture_c;
    logic                     go_resp_c;

    logic [DEPTH_WIDTH-1:0]   idx_q;
    logic                     we_q;
    logic [3:0]               sel_q;
    logic [31:0]              dat_q;

    logic                     req_c;
    logic [DEPTH_WIDTH-1:0]   acc_idx_c;
    logic                     acc_we_c;
    logic [3:0]               acc_sel_c;
    logic [31:0]              acc_dat_c;
    logic                     acc_in_range_c;

    logic [31:0]              mem [MEM_WORDS];

    logic                     unused_adr;
    assign unused_adr = ^{adr[31:DEPTH_WIDTH+2], adr[1:0]};

    assign req_c = cyc & stb;

    // With zero wait states the access completes straight from IDLE, so use live bus values there.
    always_comb begin
        acc_idx_c = idx_q;
        acc_we_c  = we_q;
        acc_sel_c = sel_q;
        acc_dat_c = dat_q;
        if (state == IDLE) begin
            acc_idx_c = adr[DEPTH_WIDTH+1:2];
            acc_we_c  = we;
            acc_sel_c = sel;
            acc_dat_c = dat_ms;
        end
        acc_in_range_c = 32'(acc_idx_c) < MEM_WORDS;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_d;
            wait_cnt <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state;
        wait_cnt_d = wait_cnt;
        capture_c  = 1'b0;
        go_resp_c  = 1'b0;
        case (state)
            IDLE: begin
                if (req_c) begin
                    capture_c = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d   = RESP;
                        go_resp_c = 1'b1;
                    end else begin
                        state_d    = WAIT;
                        wait_cnt_d = '0;
                    end
                end
            end
            WAIT: begin
                if (!req_c) begin
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_d    = RESP;
                    go_resp_c  = 1'b1;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt + CNT_W'(1);
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture, termination pulses and read data register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            we_q   <= 1'b0;
            sel_q  <= '0;
            dat_q  <= '0;
            ack    <= 1'b0;
            err    <= 1'b0;
            dat_sm <= '0;
        end else begin
            if (capture_c) begin
                idx_q <= adr[DEPTH_WIDTH+1:2];
                we_q  <= we;
                sel_q <= sel;
                dat_q <= dat_ms;
            end
            ack <= go_resp_c & acc_in_range_c;
            err <= go_resp_c & ~acc_in_range_c;
            if (go_resp_c && acc_in_range_c && !acc_we_c) begin
                dat_sm <= mem[acc_idx_c];
            end
        end
    end

    // Memory is not reset; writes are gated so an access interrupted by reset never lands.
    always_ff @(posedge clk) begin
        if (!rst && go_resp_c && acc_in_range_c && acc_we_c) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_sel_c[i]) begin
                    mem[acc_idx_c][8*i +: 8] <= acc_dat_c[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wshb_fb_slave.sv
// Randomized self-checking bench for wshb_fb_slave against an array-based memory model;
// a second instance with three wait states covers aborted and reset-interrupted accesses.
module tb_wshb_fb_slave;

    localparam int unsigned MW  = 384000;
    localparam int unsigned DW  = 19;
    localparam int unsigned MW3 = 1024;
    localparam int unsigned DW3 = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc1 = 0, stb1 = 0, we1 = 0, cyc3 = 0, stb3 = 0, we3 = 0;
    logic [3:0]  sel1 = 0, sel3 = 0;
    logic [31:0] adr1 = 0, dms1 = 0, adr3 = 0, dms3 = 0;
    logic [31:0] dsm1, dsm3;
    logic        ack1, err1, ack3, err3;

    always #5 clk = ~clk;

    wshb_fb_slave #(.MEM_WORDS(MW), .DEPTH_WIDTH(DW), .WAIT_STATES(1)) u_dut (
        .clk(clk), .rst(rst), .cyc(cyc1), .stb(stb1), .we(we1), .sel(sel1),
        .adr(adr1), .dat_ms(dms1), .dat_sm(dsm1), .ack(ack1), .err(err1));

    wshb_fb_slave #(.MEM_WORDS(MW3), .DEPTH_WIDTH(DW3), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .rst(rst), .cyc(cyc3), .stb(stb3), .we(we3), .sel(sel3),
        .adr(adr3), .dat_ms(dms3), .dat_sm(dsm3), .ack(ack3), .err(err3));

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Terminations must be exclusive single-cycle pulses on both instances.
    logic prev1 = 1'b0, prev3 = 1'b0;
    always @(negedge clk) begin
        check("excl1", 32'(ack1 & err1), 32'd0);
        check("dbl1", 32'((ack1 | err1) & prev1), 32'd0);
        check("excl3", 32'(ack3 & err3), 32'd0);
        check("dbl3", 32'((ack3 | err3) & prev3), 32'd0);
        prev1 <= ack1 | err1;
        prev3 <= ack3 | err3;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=0x%08h exp=0x%08h", 32'd1, 32'd0);
        $fatal(1, "watchdog expired");
    end

    // Reference model state
    logic [31:0] mm [int];
    logic [31:0] last_rd1;
    int          kind, lat;
    logic [31:0] rd;

    task automatic drive(input int d, input logic c, input logic s, input logic w,
                         input logic [3:0] se, input logic [31:0] a, input logic [31:0] dt);
        if (d == 1) begin
            cyc1 = c; stb1 = s; we1 = w; sel1 = se; adr1 = a; dms1 = dt;
        end else begin
            cyc3 = c; stb3 = s; we3 = w; sel3 = se; adr3 = a; dms3 = dt;
        end
    endtask

    // One single access: an idle cycle, then request until ack/err or a 20-cycle bound.
    task automatic access(input int d, input logic w, input logic [31:0] a,
                          input logic [31:0] dt, input logic [3:0] se,
                          output int k, output int l, output logic [31:0] r);
        logic a_s, e_s;
        @(posedge clk); #1;
        drive(d, 1'b1, 1'b1, w, se, a, dt);
        k = 0;
        l = 0;
        for (int i = 1; i <= 20 && k == 0; i++) begin
            @(posedge clk); #1;
            a_s = (d == 1) ? ack1 : ack3;
            e_s = (d == 1) ? err1 : err3;
            if (a_s) k = 1;
            else if (e_s) k = 2;
            l = i;
        end
        r = (d == 1) ? dsm1 : dsm3;
        drive(d, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] se);
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++) if (se[i]) res[8*i +: 8] = nw[8*i +: 8];
        return res;
    endfunction

    int unsigned pool [10];
    int          t_ack [3];

    initial begin
        // Reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack1), 32'd0);
        check("rst_err", 32'(err1), 32'd0);
        check("rst_dat", dsm1, 32'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_ack", 32'(ack1 | err1), 32'd0);
        check("idle_dat", dsm1, 32'd0);
        last_rd1 = 32'd0;

        // Full write then read, two-cycle latency with one wait state
        access(1, 1'b1, 32'h10, 32'hCAFEBABE, 4'hF, kind, lat, rd);
        check("wr10_kind", 32'(kind), 32'd1);
        check("wr10_lat", 32'(lat), 32'd2);
        check("wr10_dat", rd, last_rd1);
        access(1, 1'b0, 32'h10, 32'h0, 4'h0, kind, lat, rd);
        check("rd10_kind", 32'(kind), 32'd1);
        check("rd10_lat", 32'(lat), 32'd2);
        check("rd10_dat", rd, 32'hCAFEBABE);
        mm[4] = 32'hCAFEBABE;
        last_rd1 = rd;

        // Byte mask merge
        access(1, 1'b1, 32'h20, 32'h11223344, 4'hF, kind, lat, rd);
        access(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, kind, lat, rd);
        check("mask_wr_dat", rd, last_rd1);
        access(1, 1'b0, 32'h20, 32'h0, 4'h0, kind, lat, rd);
        check("mask_rd", rd, 32'h11BB33DD);
        mm[8] = 32'h11BB33DD;
        last_rd1 = rd;

        // Streaming reads across the top of memory and wrap to word 0
        access(1, 1'b1, 4 * (MW - 2), 32'h5EED0001, 4'hF, kind, lat, rd);
        access(1, 1'b1, 4 * (MW - 1), 32'h5EED0002, 4'hF, kind, lat, rd);
        access(1, 1'b1, 32'h0, 32'h5EED0003, 4'hF, kind, lat, rd);
        mm[MW - 2] = 32'h5EED0001;
        mm[MW - 1] = 32'h5EED0002;
        mm[0]      = 32'h5EED0003;
        begin
            int n, cyc_n, idx;
            n = 0;
            cyc_n = 0;
            idx = MW - 2;
            @(posedge clk); #1;
            drive(1, 1'b1, 1'b1, 1'b0, 4'h0, 32'(4 * idx), 32'h0);
            while (n < 3 && cyc_n < 30) begin
                @(posedge clk); #1;
                cyc_n++;
                if (ack1) begin
                    check("stream_dat", dsm1, mm[idx]);
                    t_ack[n] = cyc_n;
                    n++;
                    idx = (idx + 1) % MW;
                    if (n < 3) adr1 = 32'(4 * idx);
                    else drive(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
                end
            end
            drive(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            check("stream_cnt", 32'(n), 32'd3);
            check("stream_first", 32'(t_ack[0]), 32'd2);
            check("stream_gap1", 32'(t_ack[1] - t_ack[0]), 32'd3);
            check("stream_gap2", 32'(t_ack[2] - t_ack[1]), 32'd3);
            last_rd1 = mm[0];
        end

        // Out-of-range read and write terminate with err
        access(1, 1'b0, 4 * MW, 32'h0, 4'hF, kind, lat, rd);
        check("oor_rd_kind", 32'(kind), 32'd2);
        check("oor_rd_lat", 32'(lat), 32'd2);
        check("oor_rd_dat", rd, last_rd1);
        access(1, 1'b1, 4 * MW, 32'hDEADDEAD, 4'hF, kind, lat, rd);
        check("oor_wr_kind", 32'(kind), 32'd2);
        check("oor_wr_dat", rd, last_rd1);
        access(1, 1'b0, 32'h10, 32'h0, 4'h0, kind, lat, rd);
        check("oor_mem_intact", rd, 32'hCAFEBABE);
        last_rd1 = rd;

        // Randomized traffic over a small word pool with ignored address bits scrambled
        pool[0] = 0;
        pool[1] = MW - 1;
        for (int i = 2; i < 10; i++) pool[i] = $urandom_range(MW - 1, 0);
        for (int i = 0; i < 10; i++) begin
            logic [31:0] v;
            v = $urandom;
            access(1, 1'b1, 32'(4 * pool[i]), v, 4'hF, kind, lat, rd);
            mm[pool[i]] = v;
        end
        for (int it = 0; it < 40; it++) begin
            int unsigned idx;
            logic [31:0] a, v, exp_rd;
            logic [3:0]  se;
            logic        w;
            if ($urandom_range(7, 0) == 0) idx = MW + $urandom_range((1 << DW) - MW - 1, 0);
            else idx = pool[$urandom_range(9, 0)];
            a  = ($urandom & 32'hFFE0_0000) | 32'(idx << 2) | ($urandom & 32'h3);
            v  = $urandom;
            se = 4'($urandom);
            w  = 1'($urandom);
            access(1, w, a, v, se, kind, lat, rd);
            idx = (a >> 2) % (1 << DW);
            exp_rd = last_rd1;
            if (idx >= MW) begin
                check("rnd_err", 32'(kind), 32'd2);
            end else begin
                check("rnd_ack", 32'(kind), 32'd1);
                if (w) mm[idx] = merge(mm[idx], v, se);
                else exp_rd = mm[idx];
            end
            check("rnd_lat", 32'(lat), 32'd2);
            check("rnd_dat", rd, exp_rd);
            last_rd1 = exp_rd;
        end

        // Three wait states: aborted write leaves memory untouched
        access(3, 1'b1, 32'h40, 32'h12345678, 4'hF, kind, lat, rd);
        check("ws3_wr_lat", 32'(lat), 32'd4);
        @(posedge clk); #1;
        drive(3, 1'b1, 1'b1, 1'b1, 4'hF, 32'h40, 32'hDEADBEEF);
        repeat (2) @(posedge clk);
        #1;
        drive(3, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("abort_quiet", 32'(ack3 | err3), 32'd0);
        end
        access(3, 1'b0, 32'h40, 32'h0, 4'h0, kind, lat, rd);
        check("abort_kind", 32'(kind), 32'd1);
        check("abort_lat", 32'(lat), 32'd4);
        check("abort_dat", rd, 32'h12345678);

        // Reset during WAIT discards the pending write
        @(posedge clk); #1;
        drive(3, 1'b1, 1'b1, 1'b1, 4'hF, 32'h40, 32'h55555555);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        drive(3, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        check("rstw_quiet", 32'(ack3 | err3), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("rstw_hold", 32'(ack3 | err3), 32'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rstw_after", 32'(ack3 | err3), 32'd0);
        end
        access(3, 1'b0, 32'h40, 32'h0, 4'h0, kind, lat, rd);
        check("rstw_kind", 32'(kind), 32'd1);
        check("rstw_lat", 32'(lat), 32'd4);
        check("rstw_dat", rd, 32'h12345678);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
